// File: rtl/rr_stage_arbiter.sv
// Round-robin arbiter for one shared pipeline resource among 8 requesters.
// Drives a registered grant index/enable pair into a 3-to-8 one-hot select decoder.
module rr_stage_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       stall_in,
    output logic [2:0] grant_idx,
    output logic       grant_en,
    output logic       timeout,
    output logic [2:0] ptr_out
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // A MAX_HOLD of zero means the owner may keep the grant indefinitely.
    localparam bit                TIMEOUT_ON  = (MAX_HOLD != 0);
    localparam int                HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_LAST_I);

    state_t            state;
    state_t            state_nx;
    logic [2:0]        ptr;
    logic [2:0]        ptr_nx;
    logic [2:0]        idx_nx;
    logic              en_nx;
    logic              timeout_nx;
    logic              release_now;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nx;

    // First requester at or after position p, wrapping past bit 7.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  off;
        dbl = {r, r} >> p;
        rot = dbl[7:0];
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
        return p + off;
    endfunction

    // Saturating increment so an unlimited hold never wraps the counter.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    always_comb begin
        state_nx    = state;
        idx_nx      = grant_idx;
        en_nx       = grant_en;
        timeout_nx  = 1'b0;
        ptr_nx      = ptr;
        hold_nx     = hold_cnt;
        release_now = 1'b0;

        case (state)
            IDLE: begin
                en_nx = 1'b0;
                if (!stall_in && (req != 8'd0)) begin
                    idx_nx   = rr_pick(req, ptr);
                    en_nx    = 1'b1;
                    hold_nx  = '0;
                    state_nx = OWN;
                end
            end
            OWN: begin
                // Owner release wins over both stall and timeout.
                if (done || !req[grant_idx]) begin
                    release_now = 1'b1;
                end else if (!stall_in) begin
                    if (TIMEOUT_ON && (hold_cnt == HOLD_LAST)) begin
                        release_now = 1'b1;
                        timeout_nx  = 1'b1;
                    end else begin
                        hold_nx = hold_inc(hold_cnt);
                    end
                end

                if (release_now) begin
                    en_nx    = 1'b0;
                    ptr_nx   = grant_idx + 3'd1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= 3'd0;
            grant_en  <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nx;
            grant_idx <= idx_nx;
            grant_en  <= en_nx;
            timeout   <= timeout_nx;
            ptr       <= ptr_nx;
            hold_cnt  <= hold_nx;
        end
    end

    assign ptr_out = ptr;

endmodule

// File: tb/tb_rr_stage_arbiter.sv
// Scoreboard bench for rr_stage_arbiter: directed vectors push hand-computed
// per-cycle expectations; a monitor pops and compares after every rising edge.
module tb_rr_stage_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] req_z;
    logic       done;
    logic       stall_in;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic       timeout;
    logic [2:0] ptr_out;
    logic [2:0] grant_idx_z;
    logic       grant_en_z;
    logic       timeout_z;
    logic [2:0] ptr_out_z;
    logic       done_z;
    logic       stall_z;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       sel;
        logic       en;
        logic [2:0] idx;
        logic       to;
        logic [2:0] ptr;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];

    rr_stage_arbiter #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .stall_in  (stall_in),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .timeout   (timeout),
        .ptr_out   (ptr_out)
    );

    rr_stage_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) dut_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_z),
        .done      (done_z),
        .stall_in  (stall_z),
        .grant_idx (grant_idx_z),
        .grant_en  (grant_en_z),
        .timeout   (timeout_z),
        .ptr_out   (ptr_out_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic sel, input logic en, input logic [2:0] idx,
                                input logic to, input logic [2:0] ptr);
        exp_t e;
        e.sel = sel;
        e.en  = en;
        e.idx = idx;
        e.to  = to;
        e.ptr = ptr;
        return e;
    endfunction

    function automatic void compare(input string nm, input exp_t e, input logic en,
                                    input logic [2:0] idx, input logic to, input logic [2:0] ptr);
        n_checks++;
        if (en !== e.en || idx !== e.idx || to !== e.to || ptr !== e.ptr) begin
            n_fail++;
            $display("FAIL %s: got en=%0b idx=%0d timeout=%0b ptr=%0d, expected en=%0b idx=%0d timeout=%0b ptr=%0d",
                     nm, en, idx, to, ptr, e.en, e.idx, e.to, e.ptr);
        end
    endfunction

    // Monitor: one expectation per rising edge, sampled just after the edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                if (e.sel) begin
                    compare(nm, e, grant_en_z, grant_idx_z, timeout_z, ptr_out_z);
                end else begin
                    compare(nm, e, grant_en, grant_idx, timeout, ptr_out);
                end
            end
        end
    end

    task automatic cyc(input logic [7:0] r, input logic d, input logic s,
                       input logic e_en, input logic [2:0] e_idx, input logic e_to,
                       input logic [2:0] e_ptr, input string nm);
        req      = r;
        done     = d;
        stall_in = s;
        sb.push_back(mk(1'b0, e_en, e_idx, e_to, e_ptr));
        sb_name.push_back(nm);
        @(negedge clk);
    endtask

    task automatic cyc_z(input logic [7:0] r, input logic e_en, input logic [2:0] e_idx,
                         input logic e_to, input logic [2:0] e_ptr, input string nm);
        req   = 8'h00;
        done  = 1'b0;
        req_z = r;
        sb.push_back(mk(1'b1, e_en, e_idx, e_to, e_ptr));
        sb_name.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 8'hFF;
        req_z    = 8'h00;
        done     = 1'b0;
        stall_in = 1'b0;
        done_z   = 1'b0;
        stall_z  = 1'b0;
        @(negedge clk);

        // Reset state with all requests asserted
        cyc(8'hFF, 0, 0, 0, 3'd0, 0, 3'd0, "reset_state");
        cyc(8'hFF, 0, 0, 0, 3'd0, 0, 3'd0, "reset_state_hold");
        rst_n = 1'b1;

        // Full round robin 0..7,0 with done one cycle after each grant
        for (int k = 0; k < 9; k++) begin
            cyc(8'hFF, 0, 0, 1, 3'(k % 8), 0, 3'(k % 8), "rr_grant");
            cyc(8'hFF, 1, 0, 0, 3'(k % 8), 0, 3'((k + 1) % 8), "rr_release");
        end

        // Sparse wrap from ptr 6, non-owner changes, owner dropping req
        cyc(8'h20, 0, 0, 1, 3'd5, 0, 3'd1, "setup_grant5");
        cyc(8'h20, 1, 0, 0, 3'd5, 0, 3'd6, "setup_ptr6");
        cyc(8'h05, 0, 0, 1, 3'd0, 0, 3'd6, "wrap_grant0");
        cyc(8'h05, 1, 0, 0, 3'd0, 0, 3'd1, "wrap_ptr1");
        cyc(8'h05, 0, 0, 1, 3'd2, 0, 3'd1, "next_grant2");
        cyc(8'h07, 0, 0, 1, 3'd2, 0, 3'd1, "nonowner_ignored");
        cyc(8'h00, 0, 0, 0, 3'd2, 0, 3'd3, "drop_req_release");

        // Timeout after exactly 15 granted cycles
        cyc(8'h08, 0, 0, 1, 3'd3, 0, 3'd3, "to_grant");
        for (int i = 0; i < 14; i++) begin
            cyc(8'h08, 0, 0, 1, 3'd3, 0, 3'd3, "to_hold");
        end
        cyc(8'h08, 0, 0, 0, 3'd3, 1, 3'd4, "to_fire");
        cyc(8'h08, 0, 0, 1, 3'd3, 0, 3'd4, "to_pulse_one_cycle");
        cyc(8'h00, 0, 0, 0, 3'd3, 0, 3'd4, "to_drop");

        // Unlimited hold instance keeps the grant for 100 cycles
        cyc_z(8'h08, 1, 3'd3, 0, 3'd0, "nohold_grant");
        for (int i = 0; i < 100; i++) begin
            cyc_z(8'h08, 1, 3'd3, 0, 3'd0, "nohold_keep");
        end
        cyc_z(8'h00, 0, 3'd3, 0, 3'd4, "nohold_drop");

        // Stall of 10 cycles at hold count 3 stretches the timeout
        cyc(8'h20, 0, 0, 1, 3'd5, 0, 3'd4, "st_grant");
        for (int i = 0; i < 3; i++) begin
            cyc(8'h20, 0, 0, 1, 3'd5, 0, 3'd4, "st_pre");
        end
        for (int i = 0; i < 10; i++) begin
            cyc(8'h20, 0, 1, 1, 3'd5, 0, 3'd4, "st_frozen");
        end
        for (int i = 0; i < 11; i++) begin
            cyc(8'h20, 0, 0, 1, 3'd5, 0, 3'd4, "st_post");
        end
        cyc(8'h20, 0, 0, 0, 3'd5, 1, 3'd6, "st_timeout");
        cyc(8'h20, 0, 0, 1, 3'd5, 0, 3'd6, "st_regrant");
        cyc(8'h20, 0, 1, 1, 3'd5, 0, 3'd6, "st_stall_keep");
        cyc(8'h20, 1, 1, 0, 3'd5, 0, 3'd6, "st_done_release");
        cyc(8'h20, 0, 1, 0, 3'd5, 0, 3'd6, "st_idle_frozen");

        // done coincident with the last hold cycle releases without timeout
        cyc(8'h20, 0, 0, 1, 3'd5, 0, 3'd6, "sim_grant");
        for (int i = 0; i < 14; i++) begin
            cyc(8'h20, 0, 0, 1, 3'd5, 0, 3'd6, "sim_hold");
        end
        cyc(8'h20, 1, 0, 0, 3'd5, 0, 3'd6, "sim_done_beats_timeout");

        // Asynchronous reset mid-grant, then restart from ptr 0
        cyc(8'hFF, 0, 0, 1, 3'd6, 0, 3'd6, "rst_pre_grant");
        rst_n = 1'b0;
        #1;
        compare("async_reset", mk(1'b0, 1'b0, 3'd0, 1'b0, 3'd0), grant_en, grant_idx, timeout, ptr_out);
        cyc(8'hFF, 0, 0, 0, 3'd0, 0, 3'd0, "rst_held");
        rst_n = 1'b1;
        cyc(8'hFF, 0, 0, 1, 3'd0, 0, 3'd0, "rst_restart_ptr0");
        cyc(8'h00, 0, 0, 0, 3'd0, 0, 3'd1, "rst_final_release");

        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
